// File: rtl/fixed_bias_add_stream_if.sv
// Stream bundle for the bias-add block: joined data/bias inputs plus the
// back-pressurable result stream.
// Handshake: a beat moves on a rising clk edge where its valid and ready are
// both high. A source keeps valid and payload stable until that edge. Data and
// bias are joined, so neither ready rises unless the partner valid is high.
interface fixed_bias_add_stream_if #(
   parameter int N    = 1,
   parameter int DIP0 = 16,
   parameter int BP0  = 16,
   parameter int DOP0 = 16
);
   logic [N-1:0][DIP0-1:0] data_in;
   logic                   data_in_valid;
   logic                   data_in_ready;
   logic [N-1:0][BP0-1:0]  bias;
   logic                   bias_valid;
   logic                   bias_ready;
   logic [N-1:0][DOP0-1:0] data_out;
   logic                   data_out_valid;
   logic                   data_out_ready;
   logic                   data_out_last;
   // Output-stage occupancy (0 empty, 1 main only, 2 main + skid).
   logic [1:0]             dbg_occ;

   // The block itself.
   modport slave (
      input  data_in, data_in_valid, bias, bias_valid, data_out_ready,
      output data_in_ready, bias_ready, data_out, data_out_valid,
             data_out_last, dbg_occ
   );

   // The surroundings: matmul, bias source and downstream consumer.
   modport master (
      output data_in, data_in_valid, bias, bias_valid, data_out_ready,
      input  data_in_ready, bias_ready, data_out, data_out_valid,
             data_out_last, dbg_occ
   );
endinterface

// File: rtl/fixed_bias_add_stream.sv
// Joins a matmul result stream with a bias stream beat by beat, aligns the
// fixed-point formats, adds, floors, saturates, and presents the result
// through a registered output stage with a one-entry skid buffer. Each beat
// carries a tensor-end tag derived from row/column position counters.
module fixed_bias_add_stream #(
   parameter int DATA_IN_PRECISION_0  = 16,
   parameter int DATA_IN_PRECISION_1  = 3,
   parameter int BIAS_PRECISION_0     = 16,
   parameter int BIAS_PRECISION_1     = 3,
   parameter int DATA_OUT_PRECISION_0 = 16,
   parameter int DATA_OUT_PRECISION_1 = 3,
   parameter int TENSOR_SIZE_DIM_0    = 32,
   parameter int TENSOR_SIZE_DIM_1    = 4,
   parameter int PARALLELISM_DIM_0    = 1,
   parameter int PARALLELISM_DIM_1    = 1
) (
   input logic                       clk,
   input logic                       rst,
   fixed_bias_add_stream_if.slave    io
);

   localparam int DIP0 = DATA_IN_PRECISION_0;
   localparam int DIP1 = DATA_IN_PRECISION_1;
   localparam int BP0  = BIAS_PRECISION_0;
   localparam int BP1  = BIAS_PRECISION_1;
   localparam int DOP0 = DATA_OUT_PRECISION_0;
   localparam int DOP1 = DATA_OUT_PRECISION_1;
   localparam int N    = PARALLELISM_DIM_0 * PARALLELISM_DIM_1;
   localparam int COLS = TENSOR_SIZE_DIM_0 / PARALLELISM_DIM_0;
   localparam int ROWS = TENSOR_SIZE_DIM_1 / PARALLELISM_DIM_1;
   localparam int AL   = DIP1 - BP1;    // bias left shift into data format
   localparam int SH   = DIP1 - DOP1;   // sum right shift into output format
   localparam int SW   = DIP0 + 2;      // sum width
   localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;

   // Saturation bounds expressed at sum width; MIN is the bitwise inverse of MAX.
   localparam logic signed [SW-1:0] MAX_S = SW'(2 ** (DOP0 - 1) - 1);
   localparam logic signed [SW-1:0] MIN_S = ~MAX_S;

   // Parameter sanity: refuse formats the arithmetic cannot represent.
   if (BP1 > DIP1) begin : g_bad_bias_frac
      $error("bias fractional bits exceed data_in fractional bits");
   end
   if (DOP1 > DIP1) begin : g_bad_out_frac
      $error("data_out fractional bits exceed data_in fractional bits");
   end
   if (BP0 > DIP0) begin : g_bad_bias_width
      $error("bias width must not exceed data_in width");
   end
   if (DOP0 > SW - 1) begin : g_bad_out_width
      $error("data_out width must not exceed data_in width + 1");
   end
   if ((TENSOR_SIZE_DIM_0 % PARALLELISM_DIM_0) != 0 ||
       (TENSOR_SIZE_DIM_1 % PARALLELISM_DIM_1) != 0) begin : g_bad_par
      $error("parallelism must divide the tensor dimensions");
   end

   // Occupancy of the output stage; the skid only ever holds a beat behind main.
   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_MAIN  = 2'd1,
      OCC_FULL  = 2'd2
   } occ_e;

   occ_e occ, occ_nx;
   logic ld_main_new, ld_main_skid, ld_skid;

   logic                   skid_full;
   logic                   accept;
   logic [N-1:0][DOP0-1:0] beat_data;
   logic                   beat_last;
   logic [N-1:0][DOP0-1:0] main_data, skid_data;
   logic                   main_last, skid_last;
   logic [CW-1:0]          col_cnt;
   logic [RW-1:0]          row_cnt;

   // Align, add, floor and saturate one lane.
   function automatic logic [DOP0-1:0] lane_op(input logic [DIP0-1:0] d,
                                               input logic [BP0-1:0]  b);
      logic signed [DIP0:0]  b_al;
      logic signed [SW-1:0]  sum;
      logic signed [SW-1:0]  shd;
      b_al = $signed({{(DIP0 + 1 - BP0){b[BP0-1]}}, b}) <<< AL;
      sum  = $signed({{2{d[DIP0-1]}}, d}) + $signed({b_al[DIP0], b_al});
      shd  = sum >>> SH;
      if (shd > MAX_S) begin
         lane_op = MAX_S[DOP0-1:0];
      end else if (shd < MIN_S) begin
         lane_op = MIN_S[DOP0-1:0];
      end else begin
         lane_op = shd[DOP0-1:0];
      end
   endfunction

   assign skid_full        = (occ == OCC_FULL);
   assign accept           = io.data_in_valid & io.bias_valid & ~skid_full & ~rst;
   assign io.data_in_ready = io.bias_valid & ~skid_full & ~rst;
   assign io.bias_ready    = io.data_in_valid & ~skid_full & ~rst;
   assign beat_last        = (col_cnt == CW'(COLS - 1)) && (row_cnt == RW'(ROWS - 1));

   assign io.data_out       = main_data;
   assign io.data_out_last  = main_last;
   assign io.data_out_valid = (occ != OCC_EMPTY);
   assign io.dbg_occ        = occ;

   // Result of the beat currently offered on the inputs, all lanes.
   always_comb begin
      beat_data = '0;
      for (int j = 0; j < N; j++) begin
         beat_data[j] = lane_op(io.data_in[j], io.bias[j]);
      end
   end

   // Occupancy state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         occ <= OCC_EMPTY;
      end else begin
         occ <= occ_nx;
      end
   end

   // Next occupancy and which register loads what; skid always drains first.
   always_comb begin
      occ_nx       = occ;
      ld_main_new  = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
      case (occ)
         OCC_EMPTY: begin
            if (accept) begin
               ld_main_new = 1'b1;
               occ_nx      = OCC_MAIN;
            end
         end
         OCC_MAIN: begin
            if (accept && io.data_out_ready) begin
               ld_main_new = 1'b1;
            end else if (accept) begin
               ld_skid = 1'b1;
               occ_nx  = OCC_FULL;
            end else if (io.data_out_ready) begin
               occ_nx = OCC_EMPTY;
            end
         end
         OCC_FULL: begin
            if (io.data_out_ready) begin
               ld_main_skid = 1'b1;
               occ_nx       = OCC_MAIN;
            end
         end
         default: occ_nx = OCC_EMPTY;
      endcase
   end

   // Main and skid payload registers; the last tag travels with its beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         main_data <= '0;
         main_last <= 1'b0;
         skid_data <= '0;
         skid_last <= 1'b0;
      end else begin
         if (ld_main_new) begin
            main_data <= beat_data;
            main_last <= beat_last;
         end else if (ld_main_skid) begin
            main_data <= skid_data;
            main_last <= skid_last;
         end
         if (ld_skid) begin
            skid_data <= beat_data;
            skid_last <= beat_last;
         end
      end
   end

   // Tensor position of the next accepted beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         col_cnt <= '0;
         row_cnt <= '0;
      end else if (accept) begin
         if (col_cnt == CW'(COLS - 1)) begin
            col_cnt <= '0;
            if (row_cnt == RW'(ROWS - 1)) begin
               row_cnt <= '0;
            end else begin
               row_cnt <= row_cnt + 1'b1;
            end
         end else begin
            col_cnt <= col_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fixed_bias_add_stream.sv
// Bench for fixed_bias_add_stream: random joined traffic with random
// back-pressure checked every cycle against a queue model of the stream,
// plus literal spot values for arithmetic, join, last tagging and reset.
module tb_fixed_bias_add_stream;

   localparam int BEATS = 128;   // 32 columns x 4 rows per tensor
   localparam int W     = 17;    // {last, data}

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fixed_bias_add_stream_if #(.N(1), .DIP0(16), .BP0(16), .DOP0(16)) mif ();
   fixed_bias_add_stream_if #(.N(1), .DIP0(16), .BP0(16), .DOP0(16)) aif ();
   fixed_bias_add_stream_if #(.N(1), .DIP0(16), .BP0(16), .DOP0(16)) bif ();

   fixed_bias_add_stream #(
      .DATA_IN_PRECISION_0(16), .DATA_IN_PRECISION_1(3),
      .BIAS_PRECISION_0(16), .BIAS_PRECISION_1(3),
      .DATA_OUT_PRECISION_0(16), .DATA_OUT_PRECISION_1(3),
      .TENSOR_SIZE_DIM_0(32), .TENSOR_SIZE_DIM_1(4),
      .PARALLELISM_DIM_0(1), .PARALLELISM_DIM_1(1)
   ) dut (.clk(clk), .rst(rst), .io(mif));

   // Bias with one fractional bit, output in data format.
   fixed_bias_add_stream #(
      .DATA_IN_PRECISION_0(16), .DATA_IN_PRECISION_1(3),
      .BIAS_PRECISION_0(16), .BIAS_PRECISION_1(1),
      .DATA_OUT_PRECISION_0(16), .DATA_OUT_PRECISION_1(3),
      .TENSOR_SIZE_DIM_0(32), .TENSOR_SIZE_DIM_1(4),
      .PARALLELISM_DIM_0(1), .PARALLELISM_DIM_1(1)
   ) dut_align (.clk(clk), .rst(rst), .io(aif));

   // Bias with one fractional bit, output with one fractional bit (floors).
   fixed_bias_add_stream #(
      .DATA_IN_PRECISION_0(16), .DATA_IN_PRECISION_1(3),
      .BIAS_PRECISION_0(16), .BIAS_PRECISION_1(1),
      .DATA_OUT_PRECISION_0(16), .DATA_OUT_PRECISION_1(1),
      .TENSOR_SIZE_DIM_0(32), .TENSOR_SIZE_DIM_1(4),
      .PARALLELISM_DIM_0(1), .PARALLELISM_DIM_1(1)
   ) dut_floor (.clk(clk), .rst(rst), .io(bif));

   // ---------------- scoreboard ----------------
   int total = 0;
   int bad   = 0;
   logic [W-1:0] exp_q[$];
   int beat_idx = 0;        // accepted beats in the current tensor
   int out_cnt  = 0;        // beats delivered since reset
   int last_pos[$];         // delivery numbers that carried last
   logic rand_rdy = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Real-valued rule: value = data + bias * 2^al, floor-divide by 2^sh, clamp.
   function automatic logic [15:0] model_lane(input logic [15:0] d, input logic [15:0] b,
                                              input int al, input int sh);
      longint s;
      s = longint'($signed(d)) + longint'($signed(b)) * (longint'(1) << al);
      s = s >>> sh;
      if (s > 32767) return 16'h7FFF;
      if (s < -32768) return 16'h8000;
      return s[15:0];
   endfunction

   // Compare process: the block holds at most two beats, in order.
   always @(negedge clk) begin
      int held;
      logic [W-1:0] front;
      held = exp_q.size();
      if (rst) begin
         chk("rst_din_ready", mif.data_in_ready, 1'b0);
         chk("rst_bias_ready", mif.bias_ready, 1'b0);
         exp_q.delete();
         beat_idx = 0;
         out_cnt  = 0;
         last_pos.delete();
      end else begin
         chk("din_ready", mif.data_in_ready, mif.bias_valid && held < 2);
         chk("bias_ready", mif.bias_ready, mif.data_in_valid && held < 2);
         chk("out_valid", mif.data_out_valid, held > 0);
         chk("occupancy", mif.dbg_occ, held);
         if (held > 0) begin
            front = exp_q[0];
            chk("out_data", mif.data_out, front[15:0]);
            chk("out_last", mif.data_out_last, front[16]);
            if (mif.data_out_ready) begin
               void'(exp_q.pop_front());
               out_cnt++;
               if (front[16]) last_pos.push_back(out_cnt);
            end
         end
         if (mif.data_in_valid && mif.bias_valid && held < 2) begin
            exp_q.push_back({beat_idx == BEATS - 1,
                             model_lane(mif.data_in, mif.bias, 0, 0)});
            beat_idx = (beat_idx + 1) % BEATS;
         end
      end
   end

   // Random downstream back-pressure when enabled.
   always begin
      @(posedge clk);
      #1;
      if (rand_rdy) mif.data_out_ready = ($urandom_range(0, 3) != 0);
   end

   // ---------------- driver tasks ----------------
   function automatic logic [15:0] rnd_val();
      case ($urandom_range(0, 3))
         0: return 16'h7F00 | 16'($urandom_range(0, 255));
         1: return 16'h8000 | 16'($urandom_range(0, 255));
         default: return 16'($urandom);
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one joined beat; one side may lead the other by `lag` cycles.
   task automatic send_beat(input logic [15:0] d, input logic [15:0] b, input int lag);
      logic got;
      got = 1'b0;
      mif.data_in = d;
      mif.bias    = b;
      if (lag > 0) begin
         if ($urandom_range(0, 1) == 1) mif.data_in_valid = 1'b1;
         else mif.bias_valid = 1'b1;
         repeat (lag) step();
      end
      mif.data_in_valid = 1'b1;
      mif.bias_valid    = 1'b1;
      for (int k = 0; k < 200 && !got; k++) begin
         @(negedge clk);
         got = mif.data_in_ready;
         step();
      end
      if (!got) chk("accept_timeout", 1'b0, 1'b1);
      mif.data_in_valid = 1'b0;
      mif.bias_valid    = 1'b0;
   endtask

   task automatic send_random(input int n);
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 3) == 0 ? $urandom_range(1, 2) : 0) step();
         send_beat(rnd_val(), rnd_val(), ($urandom_range(0, 4) == 0) ? $urandom_range(1, 2) : 0);
      end
   endtask

   task automatic wait_out(input int target);
      for (int k = 0; k < 3000 && out_cnt < target; k++) step();
      chk("drain_count", out_cnt, target);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) step();
      rst = 1'b0;
   endtask

   task automatic aux_beat(input logic [15:0] d, input logic [15:0] b);
      aif.data_in = d;  aif.bias = b;  aif.data_in_valid = 1'b1;  aif.bias_valid = 1'b1;
      bif.data_in = d;  bif.bias = b;  bif.data_in_valid = 1'b1;  bif.bias_valid = 1'b1;
      step();
      chk("align_valid", aif.data_out_valid, 1'b1);
      chk("align_data", aif.data_out, model_lane(d, b, 2, 0));
      chk("floor_valid", bif.data_out_valid, 1'b1);
      chk("floor_data", bif.data_out, model_lane(d, b, 2, 2));
      aif.data_in_valid = 1'b0;  aif.bias_valid = 1'b0;
      bif.data_in_valid = 1'b0;  bif.bias_valid = 1'b0;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [15:0] d0, d1;
      int acc;
      mif.data_in = '0;  mif.bias = '0;  mif.data_in_valid = 1'b0;
      mif.bias_valid = 1'b0;  mif.data_out_ready = 1'b1;
      aif.data_in = '0;  aif.bias = '0;  aif.data_in_valid = 1'b0;
      aif.bias_valid = 1'b0;  aif.data_out_ready = 1'b1;
      bif.data_in = '0;  bif.bias = '0;  bif.data_in_valid = 1'b0;
      bif.bias_valid = 1'b0;  bif.data_out_ready = 1'b1;
      repeat (3) step();
      rst = 1'b0;

      // Reset state.
      chk("reset_valid", mif.data_out_valid, 1'b0);
      chk("reset_last", mif.data_out_last, 1'b0);
      chk("reset_data", mif.data_out, 16'h0000);

      // Model pins and one-cycle latency.
      chk("model_pin_sat_hi", model_lane(16'h7FF0, 16'h0100, 0, 0), 16'h7FFF);
      chk("model_pin_floor", model_lane(16'hFFFB, 16'h0000, 2, 2), 16'hFFFE);
      send_beat(16'h0010, 16'h0008, 0);
      chk("t1_identity", mif.data_out, 16'h0018);
      chk("t1_latency", mif.data_out_valid, 1'b1);
      send_beat(16'h7FF0, 16'h0100, 0);
      chk("t3_sat_hi", mif.data_out, 16'h7FFF);
      send_beat(16'h8000, 16'hFFFF, 0);
      chk("t3_sat_lo", mif.data_out, 16'h8000);
      step();

      // Alignment and flooring on the alternate formats.
      aux_beat(16'h0004, 16'h0001);
      chk("t2_align", aif.data_out, 16'h0008);
      chk("t2_floor", bif.data_out, 16'h0002);
      aux_beat(16'hFFFB, 16'h0000);
      chk("floor_neg", bif.data_out, 16'hFFFE);
      for (int i = 0; i < 20; i++) aux_beat(16'($urandom), 16'($signed(16'($urandom)) >>> 2));

      // Join: data alone is never consumed.
      mif.data_in = 16'h0123;  mif.data_in_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("t4a_din_ready", mif.data_in_ready, 1'b0);
         step();
      end
      chk("t4a_no_out", mif.data_out_valid, 1'b0);
      mif.data_in_valid = 1'b0;
      step();

      // Back-pressure: five stalled cycles hold exactly two beats.
      mif.data_out_ready = 1'b0;
      d0 = 16'h0100;  d1 = 16'h0200;
      mif.data_in = d0;  mif.bias = '0;
      mif.data_in_valid = 1'b1;  mif.bias_valid = 1'b1;
      acc = 0;
      repeat (5) begin
         logic got;
         @(negedge clk);
         got = mif.data_in_ready;
         step();
         if (got) begin
            acc++;
            mif.data_in = (acc == 1) ? d1 : 16'h0300 + 16'(acc);
         end
      end
      chk("t4b_held", acc, 2);
      chk("t4b_din_ready", mif.data_in_ready, 1'b0);
      chk("t4b_bias_ready", mif.bias_ready, 1'b0);
      mif.data_in_valid = 1'b0;  mif.bias_valid = 1'b0;
      mif.data_out_ready = 1'b1;
      chk("t4b_first", mif.data_out, d0);
      step();
      chk("t4b_second", mif.data_out, d1);
      step();
      chk("t4b_drained", mif.data_out_valid, 1'b0);

      // Tensor-end tagging over two tensors with random traffic.
      do_reset();
      rand_rdy = 1'b1;
      send_random(2 * BEATS);
      wait_out(2 * BEATS);
      rand_rdy = 1'b0;
      mif.data_out_ready = 1'b1;
      chk("t5_last_count", last_pos.size(), 2);
      if (last_pos.size() == 2) begin
         chk("t5_last_first", last_pos[0], BEATS);
         chk("t5_last_second", last_pos[1], 2 * BEATS);
      end

      // Reset with main and skid both full.
      mif.data_out_ready = 1'b0;
      mif.data_in = 16'h0042;  mif.bias = 16'h0001;
      mif.data_in_valid = 1'b1;  mif.bias_valid = 1'b1;
      repeat (4) step();
      chk("t6_full", mif.dbg_occ, 2'd2);
      rst = 1'b1;
      step();
      chk("t6_valid", mif.data_out_valid, 1'b0);
      chk("t6_last", mif.data_out_last, 1'b0);
      chk("t6_data", mif.data_out, 16'h0000);
      rst = 1'b0;
      mif.data_in_valid = 1'b0;  mif.bias_valid = 1'b0;
      rand_rdy = 1'b1;
      send_random(BEATS + 2);
      wait_out(BEATS + 2);
      rand_rdy = 1'b0;
      mif.data_out_ready = 1'b1;
      chk("t6_last_count", last_pos.size(), 1);
      if (last_pos.size() == 1) chk("t6_last_pos", last_pos[0], BEATS);

      repeat (2) step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard bound on run time.
   initial begin
      #500000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
